// File: rtl/nibble_history_display_if.sv
// Bus between the code converter / board controls and the display block.
// The master drives the captured word and requests, the slave drives the display.
interface nibble_history_display_if;
    logic [3:0] din;
    logic       load;
    logic       clear;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [3:0] hist_valid;

    modport master (
        output din, load, clear,
        input  seg, an, dp, hist_valid
    );

    modport slave (
        input  din, load, clear,
        output seg, an, dp, hist_valid
    );
endinterface

// File: rtl/nibble_history_display.sv
// Four-deep capture history of converter words on a multiplexed
// seven-segment display, newest value on digit 0.
module nibble_history_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    nibble_history_display_if.slave        bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);

    logic          r_ld_s1, r_ld_s2, r_ld_prev;
    logic          r_cl_s1, r_cl_s2;
    logic [3:0]    r_hist [4];
    logic [3:0]    r_hv;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_dp;

    logic          w_load_edge;
    logic [3:0]    w_cur;
    logic          w_cur_vld;
    logic [6:0]    w_hex;

    assign w_load_edge = r_ld_s2 & ~r_ld_prev;
    assign w_cur       = r_hist[r_idx];
    assign w_cur_vld   = r_hv[r_idx];

    // Bring the button and switch into the clk domain, keep load history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_s1   <= 1'b0;
            r_ld_s2   <= 1'b0;
            r_ld_prev <= 1'b0;
            r_cl_s1   <= 1'b0;
            r_cl_s2   <= 1'b0;
        end else begin
            r_ld_s1   <= bus.load;
            r_ld_s2   <= r_ld_s1;
            r_ld_prev <= r_ld_s2;
            r_cl_s1   <= bus.clear;
            r_cl_s2   <= r_cl_s1;
        end
    end

    // History shift register; clear wins over a coincident capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_hist[i] <= 4'h0;
            r_hv <= 4'h0;
        end else if (r_cl_s2) begin
            for (int i = 0; i < 4; i++) r_hist[i] <= 4'h0;
            r_hv <= 4'h0;
        end else if (w_load_edge) begin
            r_hist[3] <= r_hist[2];
            r_hist[2] <= r_hist[1];
            r_hist[1] <= r_hist[0];
            r_hist[0] <= bus.din;
            r_hv      <= {r_hv[2:0], 1'b1};
        end
    end

    // Digit scan: prescaler terminal count advances the digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (r_presc == TC) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Active-low gfedcba hex font
    always_comb begin
        w_hex = 7'h7F;
        unique case (w_cur)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
        endcase
    end

    // Registered display drive so the pins change glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'h7F;
            r_an  <= 4'hF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_cur_vld ? w_hex : 7'h7F;
            r_dp  <= ~((r_idx == 2'd0) & r_hv[0]);
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.dp         = r_dp;
    assign bus.hist_valid = r_hv;

endmodule

// File: tb/tb_nibble_history_display.sv
// Bench for nibble_history_display: reference model, hex table,
// scan/overflow/clear/reset/latency sequences and random traffic.
module tb_nibble_history_display;

    localparam int SCAN_DIV = 4;

    typedef struct {
        logic [3:0] din;
        logic [6:0] seg;
    } vec_t;

    logic clk;
    logic rst_n;

    nibble_history_display_if bus();

    nibble_history_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    logic [6:0] HEX [16];
    vec_t       vt  [16];

    // Reference model: captured values, newest first
    logic [3:0] q [$];
    logic       ld_s [$];
    logic       cl_s [$];
    int         c;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    logic [3:0] e_hv;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ld_s = '{1'b0, 1'b0, 1'b0};
        cl_s = '{1'b0, 1'b0, 1'b0};
        c     = 0;
        e_seg = 7'h7F;
        e_an  = 4'hF;
        e_dp  = 1'b1;
        e_hv  = 4'h0;
    endtask

    // Called at each rising edge with reset released.
    // A request sampled at edge n acts at edge n+2.
    task automatic model_edge();
        int   idx;
        logic cap;
        logic clr;
        c++;
        idx   = ((c - 1) / SCAN_DIV) % 4;
        e_an  = ~(4'b0001 << idx);
        e_seg = (idx < q.size()) ? HEX[q[idx]] : 7'h7F;
        e_dp  = !(idx == 0 && q.size() > 0);
        cap   = ld_s[1] & ~ld_s[2];
        clr   = cl_s[1];
        if (clr) begin
            q.delete();
        end else if (cap) begin
            q.push_front(bus.din);
            if (q.size() > 4) void'(q.pop_back());
        end
        ld_s.push_front(bus.load);
        void'(ld_s.pop_back());
        cl_s.push_front(bus.clear);
        void'(cl_s.pop_back());
        e_hv = 4'((1 << q.size()) - 1);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".seg"}, 32'(bus.seg), 32'(e_seg));
        chk({tag, ".an"},  32'(bus.an),  32'(e_an));
        chk({tag, ".dp"},  32'(bus.dp),  32'(e_dp));
        chk({tag, ".hv"},  32'(bus.hist_valid), 32'(e_hv));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic capture(input logic [3:0] v, input string tag);
        bus.din  = v;
        bus.load = 1'b1;
        ticks(tag, 2);
        bus.load = 1'b0;
        ticks(tag, 3);
    endtask

    task automatic wait_digit0(input string tag);
        int w;
        w = 0;
        while (e_an !== 4'b1110 && w < 20) begin
            tick(tag);
            w++;
        end
        if (w >= 20) chk({tag, ".timeout"}, 32'(w), 32'(0));
    endtask

    initial begin
        logic [3:0] hv0;
        n_chk  = 0;
        n_fail = 0;
        HEX = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 16; i++) begin
            vt[i].din = 4'(i);
            vt[i].seg = HEX[i];
        end

        rst_n     = 1'b0;
        bus.din   = 4'h0;
        bus.load  = 1'b0;
        bus.clear = 1'b0;
        model_reset();
        #8;
        check_all("reset");
        #4 rst_n = 1'b1;

        // Scan order with empty history
        ticks("scan", 4);
        chk("scan.an0", 32'(bus.an), 32'hE);
        tick("scan");
        chk("scan.an1", 32'(bus.an), 32'hD);
        ticks("scan", 15);

        // Single held load
        bus.din  = 4'hB;
        bus.load = 1'b1;
        ticks("hold", 10);
        bus.load = 1'b0;
        ticks("hold", 16);
        chk("hold.hv", 32'(bus.hist_valid), 32'h1);
        wait_digit0("hold");
        chk("hold.seg", 32'(bus.seg), 32'h03);
        chk("hold.dp", 32'(bus.dp), 32'h0);

        // Overflow
        for (int v = 1; v <= 5; v++) capture(4'(v), "ovf");
        chk("ovf.hv", 32'(bus.hist_valid), 32'hF);
        wait_digit0("ovf");
        chk("ovf.d0", 32'(bus.seg), 32'h12);
        ticks("ovf", 4);
        chk("ovf.d1", 32'(bus.seg), 32'h19);
        ticks("ovf", 4);
        chk("ovf.d2", 32'(bus.seg), 32'h30);
        ticks("ovf", 4);
        chk("ovf.d3", 32'(bus.seg), 32'h24);

        // Clear and load together
        bus.din   = 4'h7;
        bus.clear = 1'b1;
        bus.load  = 1'b1;
        ticks("clr", 6);
        chk("clr.hv", 32'(bus.hist_valid), 32'h0);
        bus.load = 1'b0;
        ticks("clr", 16);
        bus.clear = 1'b0;
        ticks("clr", 4);
        chk("clr.hv2", 32'(bus.hist_valid), 32'h0);

        // Async reset mid-scan with full history
        for (int v = 8; v < 12; v++) capture(4'(v), "rst");
        ticks("rst", 2);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        #3 rst_n = 1'b1;
        ticks("arst", 4);
        chk("arst.an", 32'(bus.an), 32'hE);
        ticks("arst", 4);

        // Capture latency
        hv0 = e_hv;
        #8 bus.din = 4'hC;
        bus.load = 1'b1;
        tick("lat");
        chk("lat.k", 32'(bus.hist_valid), 32'(hv0));
        tick("lat");
        chk("lat.k1", 32'(bus.hist_valid), 32'(hv0));
        tick("lat");
        chk("lat.k2", 32'(bus.hist_valid), 32'({hv0[2:0], 1'b1}));
        bus.load = 1'b0;
        ticks("lat", 4);

        // Hex font table
        for (int i = 0; i < 16; i++) begin
            capture(vt[i].din, "font");
            wait_digit0("font");
            chk($sformatf("font%0h", i), 32'(bus.seg), 32'(vt[i].seg));
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.load  = ($urandom_range(0, 3) == 0);
            bus.clear = ($urandom_range(0, 24) == 0);
            bus.din   = 4'($urandom);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_history_display.md
Name: nibble_history_display

Overview:
- Downstream consumer of the 4-bit gate-level code converter output on the lab board.
- Captures the converter's 4-bit result on a button press and keeps the last four captured values.
- Shows them on a 4-digit multiplexed seven-segment display. Digit 0 holds the newest value; empty slots are blanked.

Parameters:
SCAN_DIV, 50000, clk cycles each digit is driven before advancing; legal range >= 2

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
din  input  4  converter output word to capture
load  input  1  capture request from push-button, asynchronous to clk
clear  input  1  history clear from switch, asynchronous to clk
seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
an  output  4  digit enables, active-low, an[0] = newest-value digit
dp  output  1  decimal point, active-low
hist_valid  output  4  bit i = 1 when history slot i holds a captured value

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - hist[0..3] = 0, hist_valid = 0.
  - seg = 7'h7F, an = 4'hF, dp = 1.
  - Prescaler = 0, digit index = 0, all synchronizer flops = 0.
- Input conditioning:
  - load and clear each pass through a 2-flop synchronizer.
  - A third register holds the previous synchronized load value.
  - load_edge = sync_load & ~prev_load.
- Capture on load_edge:
  - hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=hist[0], hist[0]<=din.
  - hist_valid <= {hist_valid[2:0],1'b1}.
  - Latency: the capture occurs on the 3rd rising clk edge, counting the first edge that samples load=1. din must be stable across that window.
  - Holding load high for any length produces exactly one capture. A fifth and later capture discards the oldest value.
- Clear:
  - While synchronized clear = 1, hist and hist_valid are held at 0.
  - Clear has priority over a simultaneous load_edge; that capture is lost.
  - Scanning continues during clear, so all digits show blank.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the digit index increments mod 4 (3 -> 0).
  - Scan order: digit 0,1,2,3,0,...
- Output stage (all registered, updated one cycle after index/data change):
  - an = all ones except bit[index] = 0.
  - seg = hex decode of hist[index] when hist_valid[index] = 1, else 7'h7F.
  - dp = 0 only when index = 0 and hist_valid[0] = 1; otherwise 1.
- Hex decode (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Display update timing:
  - A capture while a digit is displayed appears on seg no later than the next clk edge.
  - The scan phase is not disturbed by a capture.
- Reset mid-scan or mid-capture: everything returns to reset values at once. Scanning restarts at digit 0 with the prescaler at 0 on the first edge after rst_n rises.

Test Plan:
(all scenarios use SCAN_DIV=4)
1. Scan order: after reset with no loads, observe an -> 1110,1101,1011,0111 each held 4 cycles, then wraps to 1110. seg=7F and dp=1 throughout.
2. Single held load: din=4'hB, load high for 10 cycles -> exactly one capture; hist_valid=0001. When an=1110: seg=7'h03, dp=0. When an is on any other digit: seg=7F.
3. Overflow: load din=1,2,3,4,5 in sequence (each load released before the next) -> hist_valid=1111. an0..an3 show seg 12,19,30,24, i.e. 5,4,3,2. Value 1 has been discarded.
4. Clear priority: with history full, raise clear and load on the same cycle -> hist_valid=0 and hist unchanged at 0 afterwards. All digits seg=7F.
5. Async reset mid-scan: with history full, pull rst_n low between clock edges -> seg=7F, an=F, dp=1, hist_valid=0 immediately, before the next clk edge. After release, an=1110 for the first 4 cycles.
6. Capture latency: raise load 1 ns before edge k -> hist_valid changes at edge k+2, not at k+1.
